// File: rtl/sync_n_fifo.sv
// sync_n_fifo: lockstep multi-lane FIFO.
// LANES independent write streams share a single consumer that pops every
// lane at once. Each lane has its own storage, pointers, occupancy count,
// almost-full and full indication.
// Optional feature macro: SYNC_N_FIFO_ERR_EN builds sticky overflow/underflow
// flags; without it those outputs are tied low and err_clr_in is unused.

module sync_n_fifo #(
    parameter int LANES        = 2,
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 512,
    parameter int AFULL_THRESH = 480
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [LANES-1:0]               write_en_in,
    input  logic [LANES*WIDTH-1:0]         data_in,
    output logic [LANES-1:0]               afull_out,
    output logic [LANES-1:0]               full_out,
    output logic [LANES*($clog2(DEPTH)+1)-1:0] count_out,
    output logic                           empty_out,
    input  logic                           read_en_in,
    output logic [LANES*WIDTH-1:0]         data_out,
    output logic [LANES-1:0]               overflow_out,
    output logic                           underflow_out,
    input  logic                           err_clr_in
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds sized to the count registers so comparisons stay width-clean.
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AFULL = (AW+1)'(AFULL_THRESH);

    logic [WIDTH-1:0] r_mem    [LANES][DEPTH];
    logic [AW-1:0]    r_wrPtr  [LANES];
    logic [AW-1:0]    r_rdPtr  [LANES];
    logic [AW:0]      r_count  [LANES];
    logic [LANES*WIDTH-1:0] r_dataOut;

    logic [LANES-1:0] w_full;
    logic [LANES-1:0] w_afull;
    logic [LANES-1:0] w_push;
    logic             w_empty;
    logic             w_pop;

    // Per-lane decodes of the registered occupancy and the accepted pushes.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_full[g]  = (r_count[g] == C_DEPTH);
        assign w_afull[g] = (r_count[g] >= C_AFULL);
        assign w_push[g]  = write_en_in[g] && !w_full[g];
        assign count_out[g*(AW+1) +: AW+1] = r_count[g];
    end

    // The consumer sees "empty" as soon as any single lane has nothing to give.
    always_comb begin
        w_empty = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (r_count[i] == '0) begin
                w_empty = 1'b1;
            end
        end
    end

    assign w_pop     = read_en_in && !w_empty;
    assign full_out  = w_full;
    assign afull_out = w_afull;
    assign empty_out = w_empty;
    assign data_out  = r_dataOut;

    // Storage is deliberately not reset; accepted pushes write at the lane's write pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wrPtr[i]] <= data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer and occupancy bookkeeping; a push while full was already gated out of w_push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (w_push[i]) begin
                    r_wrPtr[i] <= r_wrPtr[i] + 1'b1;
                end
                if (w_pop) begin
                    r_rdPtr[i] <= r_rdPtr[i] + 1'b1;
                end
                unique case ({w_push[i], w_pop})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Registered read port: loaded from every lane's head on a pop, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dataOut <= '0;
        end else if (w_pop) begin
            for (int i = 0; i < LANES; i++) begin
                r_dataOut[i*WIDTH +: WIDTH] <= r_mem[i][r_rdPtr[i]];
            end
        end
    end

`ifdef SYNC_N_FIFO_ERR_EN
    logic [LANES-1:0] r_overflow;
    logic             r_underflow;

    // Sticky error flags; a fresh error in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (write_en_in[i] && w_full[i]) begin
                    r_overflow[i] <= 1'b1;
                end else if (err_clr_in) begin
                    r_overflow[i] <= 1'b0;
                end
            end
            if (read_en_in && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr_in) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow_out  = r_overflow;
    assign underflow_out = r_underflow;
`else
    logic w_unusedErrClr;

    assign w_unusedErrClr = err_clr_in;
    assign overflow_out   = '0;
    assign underflow_out  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_n_fifo.sv
// tb_sync_n_fifo: directed, self-checking bench for sync_n_fifo with
// LANES=2, WIDTH=8, DEPTH=8, AFULL_THRESH=6. Expected error-flag values
// follow SYNC_N_FIFO_ERR_EN so the bench suits both builds.

module tb_sync_n_fifo;

    localparam int LANES = 2;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;
    localparam int AW    = 3;

`ifdef SYNC_N_FIFO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [LANES-1:0]         write_en_in;
    logic [LANES*WIDTH-1:0]   data_in;
    logic [LANES-1:0]         afull_out;
    logic [LANES-1:0]         full_out;
    logic [LANES*(AW+1)-1:0]  count_out;
    logic                     empty_out;
    logic                     read_en_in;
    logic [LANES*WIDTH-1:0]   data_out;
    logic [LANES-1:0]         overflow_out;
    logic                     underflow_out;
    logic                     err_clr_in;

    int nChecks = 0;
    int nFails  = 0;

    sync_n_fifo #(
        .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .write_en_in(write_en_in), .data_in(data_in),
        .afull_out(afull_out), .full_out(full_out), .count_out(count_out),
        .empty_out(empty_out), .read_en_in(read_en_in), .data_out(data_out),
        .overflow_out(overflow_out), .underflow_out(underflow_out),
        .err_clr_in(err_clr_in)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then return to idle 1 ns later.
    task automatic applyStimulus(input logic [1:0] we, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic re, input logic clr);
        write_en_in = we;
        data_in     = {d1, d0};
        read_en_in  = re;
        err_clr_in  = clr;
        @(posedge clk);
        #1;
        write_en_in = '0;
        data_in     = '0;
        read_en_in  = 1'b0;
        err_clr_in  = 1'b0;
    endtask

    initial begin
        logic [7:0] pushSeq;
        logic [7:0] popSeq;
        int         cnt;

        rst_n       = 1'b0;
        write_en_in = '0;
        data_in     = '0;
        read_en_in  = 1'b0;
        err_clr_in  = 1'b0;

        // Power-on reset state.
        #12;
        checkOutput("rst_count", 32'(count_out), 32'h00);
        checkOutput("rst_empty", 32'(empty_out), 32'h1);
        checkOutput("rst_full", 32'(full_out), 32'h0);
        checkOutput("rst_afull", 32'(afull_out), 32'h0);
        checkOutput("rst_data", 32'(data_out), 32'h0000);
        checkOutput("rst_ovf", 32'(overflow_out), 32'h0);
        checkOutput("rst_udf", 32'(underflow_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Uneven lanes: empty stays high until lane 1 gets an entry.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b01, 8'hA0 + 8'(k), 8'h00, 1'b0, 1'b0);
            checkOutput("uneven_empty", 32'(empty_out), 32'h1);
        end
        checkOutput("uneven_count", 32'(count_out), 32'h04);
        applyStimulus(2'b10, 8'h00, 8'hB0, 1'b0, 1'b0);
        checkOutput("lane1_empty", 32'(empty_out), 32'h0);
        checkOutput("lane1_count", 32'(count_out), 32'h14);
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        checkOutput("pop_data", 32'(data_out), 32'hB0A0);
        checkOutput("pop_count", 32'(count_out), 32'h03);
        checkOutput("pop_empty", 32'(empty_out), 32'h1);

        // Pop while empty: ignored, data held, underflow flagged (when built).
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        checkOutput("udf_data", 32'(data_out), 32'hB0A0);
        checkOutput("udf_count", 32'(count_out), 32'h03);
        checkOutput("udf_flag", 32'(underflow_out), 32'(ERR_EN));
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
        checkOutput("udf_clr_vs_set", 32'(underflow_out), 32'(ERR_EN));
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("udf_clr", 32'(underflow_out), 32'h0);

        // Build up 5 entries per lane, then reset asynchronously mid-cycle.
        applyStimulus(2'b11, 8'hC0, 8'hD0, 1'b0, 1'b0);
        applyStimulus(2'b11, 8'hC1, 8'hD1, 1'b0, 1'b0);
        for (int k = 2; k < 5; k++) begin
            applyStimulus(2'b10, 8'h00, 8'hD0 + 8'(k), 1'b0, 1'b0);
        end
        checkOutput("pre_rst_count", 32'(count_out), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_count", 32'(count_out), 32'h00);
        checkOutput("async_rst_empty", 32'(empty_out), 32'h1);
        checkOutput("async_rst_data", 32'(data_out), 32'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill lane 0: almost-full at 6, full at 8, 9th push dropped.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(2'b01, 8'h10 + 8'(k), 8'h00, 1'b0, 1'b0);
            checkOutput("afull0", 32'(afull_out), (k + 1 >= AFULL) ? 32'h1 : 32'h0);
            checkOutput("full0", 32'(full_out), (k + 1 == DEPTH) ? 32'h1 : 32'h0);
        end
        applyStimulus(2'b01, 8'hFF, 8'h00, 1'b0, 1'b0);
        checkOutput("drop_count", 32'(count_out), 32'h08);
        checkOutput("ovf_flag", 32'(overflow_out), {31'b0, ERR_EN});

        // Fill lane 1, then push and pop together at full.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(2'b10, 8'h00, 8'h20 + 8'(k), 1'b0, 1'b0);
        end
        checkOutput("both_full", 32'(full_out), 32'h3);
        checkOutput("both_count", 32'(count_out), 32'h88);
        applyStimulus(2'b11, 8'hEE, 8'hEE, 1'b1, 1'b0);
        checkOutput("pushpop_count", 32'(count_out), 32'h77);
        checkOutput("pushpop_data", 32'(data_out), 32'h2010);
        checkOutput("pushpop_full", 32'(full_out), 32'h0);
        checkOutput("pushpop_ovf", 32'(overflow_out), {30'b0, ERR_EN, ERR_EN});
        for (int k = 1; k < DEPTH; k++) begin
            applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
            checkOutput("drain_data", 32'(data_out), {16'h0, 8'h20 + 8'(k), 8'h10 + 8'(k)});
        end
        checkOutput("drain_count", 32'(count_out), 32'h00);
        checkOutput("drain_empty", 32'(empty_out), 32'h1);
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("ovf_clr", 32'(overflow_out), 32'h0);

        // Offset the pointers, then fill and drain three times across the wrap.
        pushSeq = 8'h50;
        popSeq  = 8'h50;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, pushSeq, pushSeq + 8'h40, 1'b0, 1'b0);
            pushSeq++;
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
            checkOutput("offset_data", 32'(data_out), {16'h0, popSeq + 8'h40, popSeq});
            popSeq++;
        end
        for (int r = 0; r < 3; r++) begin
            cnt = 0;
            for (int k = 0; k < DEPTH; k++) begin
                applyStimulus(2'b11, pushSeq, pushSeq + 8'h40, 1'b0, 1'b0);
                pushSeq++;
                cnt++;
                checkOutput("wrap_fill_count", 32'(count_out), 32'((cnt << 4) | cnt));
            end
            applyStimulus(2'b11, 8'hEE, 8'hEE, 1'b0, 1'b0);
            checkOutput("wrap_cap_count", 32'(count_out), 32'h88);
            for (int k = 0; k < DEPTH; k++) begin
                applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
                checkOutput("wrap_data", 32'(data_out), {16'h0, popSeq + 8'h40, popSeq});
                popSeq++;
            end
            checkOutput("wrap_empty", 32'(empty_out), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sync_n_fifo.md
# sync_n_fifo

Parametrised lockstep multi-lane FIFO for the build engine. It buffers LANES independent write streams, each with its own write enable and almost-full back-pressure, and presents them to a single consumer that pops all lanes together. It replaces fixed two-lane, vendor-IP-based lane buffers with inferred storage and configurable width, depth, lane count and almost-full threshold. It also exposes per-lane occupancy and optional sticky error flags.

## Interface
- LANES, 2, number of lanes (≥1)
- WIDTH, 64, data bits per lane
- DEPTH, 512, entries per lane; power of two, ≥4
- AFULL_THRESH, 480, per-lane almost-full level; 1..DEPTH
- AW = log2(DEPTH), derived, not overridable
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- write_en_in  in  LANES  per-lane push request
- data_in  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- afull_out  out  LANES  lane occupancy ≥ AFULL_THRESH
- full_out  out  LANES  lane occupancy == DEPTH
- count_out  out  LANES*(AW+1)  lane i occupancy at [i*(AW+1) +: AW+1]
- empty_out  out  1  any lane empty
- read_en_in  in  1  pop one entry from every lane
- data_out  out  LANES*WIDTH  popped entries, same packing as data_in
- overflow_out  out  LANES  sticky: push attempted while lane full
- underflow_out  out  1  sticky: pop attempted while empty_out
- err_clr_in  in  1  synchronous clear of sticky flags

## Operation
- Per lane: DEPTH×WIDTH storage, wr_ptr/rd_ptr AW bits wrapping modulo DEPTH, count AW+1 bits.
- Push on lane i: write_en_in[i] && !full_out[i]. Write data at wr_ptr, then increment wr_ptr.
- Pop: read_en_in && !empty_out. Every lane increments rd_ptr and decrements count in the same cycle.
- A push while full is dropped. A pop while empty_out is ignored, and no lane moves.
- Simultaneous push and pop on a lane: count unchanged, both pointers advance. This is legal at count==DEPTH: full_out gates the push, so only the pop happens.
- full_out, afull_out and empty_out are combinational decodes of the registered counts.
- empty_out = OR over lanes of (count==0).
- data_out is registered. It is loaded from each lane's rd_ptr entry on a pop and holds its value otherwise.

## Timing
- Reset (rst_n low, asynchronous): pointers=0, counts=0, data_out=0, overflow_out=0, underflow_out=0. This gives empty_out=1, full_out=0, afull_out=0.
- Storage contents are not reset. A reset mid-operation discards all entries.
- Push at edge N: count_out and the flags reflect it after edge N. The earliest pop of that entry is at edge N+1.
- Pop at edge N: data_out is valid after edge N (one-cycle read latency). Flags update after the same edge.
- Lanes written unevenly: empty_out stays high until the slowest lane holds ≥1 entry.
- Pointer wrap DEPTH-1→0 is seamless. Occupancy is bounded 0..DEPTH.

## Configuration
- SYNC_N_FIFO_ERR_EN defined: overflow_out[i] sets on write_en_in[i] && full_out[i], and underflow_out sets on read_en_in && empty_out. Both hold until err_clr_in or reset. If err_clr_in and a new error occur in the same cycle, the flag sets.
- SYNC_N_FIFO_ERR_EN undefined: overflow_out and underflow_out are tied to 0, err_clr_in is ignored, and no flag registers are built. The drop/ignore behaviour is unchanged.

## Test plan
- Reset mid-traffic with LANES=2: assert rst_n low with 5 entries per lane -> count_out=0, empty_out=1, data_out=0 immediately, without waiting for a clock edge.
- Push 0xA0..0xA3 on lane 0 only -> empty_out stays 1. Then push 0xB0 on lane 1 -> empty_out=0 next cycle. Pop -> data_out={0xB0,0xA0}.
- DEPTH=8, AFULL_THRESH=6: push 6 on lane 0 -> afull_out[0]=1 after the 6th edge. Push 2 more -> full_out[0]=1. A 9th push is dropped, and overflow_out[0]=1 when SYNC_N_FIFO_ERR_EN is defined.
- At count 8 on both lanes, push and pop in the same cycle -> counts=7, and the pushed data is not stored.
- Fill and drain lanes 3 times with DEPTH=8 and incrementing data -> data is returned in order across pointer wrap, and count never exceeds 8.
- Pop while empty -> no pointer change, data_out holds, and underflow_out=1. Then pulse err_clr_in -> underflow_out=0 on the next edge.
